// File: rtl/rob_commit_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_unit_if
//  Description : Bundle of the decode-issue, operand-query, common-data-bus
//                and commit signals seen by the reorder buffer.
//                slave  modport : the reorder buffer itself.
//                master modport : the surrounding pipeline (decode, ALU, LSB,
//                                 register file).
//  Ports       : out_decode_freetag / in_decode_destination / in_decode_op
//                in_fetch_tag1/2 -> out_fetch_value1/2, out_fetch_ready1/2
//                in_alu_cdb_tag/value, in_lsb_cdb_tag/value
//                out_reg_commit_dest/value/tag, out_lsb_commit_tag, out_full
//  Revision    : 1.0  initial release
// ============================================================================
interface rob_commit_unit_if #(
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
);
    logic [TAG_W-1:0] out_decode_freetag;
    logic [31:0]      in_decode_destination;
    logic [OP_W-1:0]  in_decode_op;

    logic [TAG_W-1:0] in_fetch_tag1;
    logic [31:0]      out_fetch_value1;
    logic             out_fetch_ready1;
    logic [TAG_W-1:0] in_fetch_tag2;
    logic [31:0]      out_fetch_value2;
    logic             out_fetch_ready2;

    logic [TAG_W-1:0] in_alu_cdb_tag;
    logic [31:0]      in_alu_cdb_value;
    logic [TAG_W-1:0] in_lsb_cdb_tag;
    logic [31:0]      in_lsb_cdb_value;

    logic [4:0]       out_reg_commit_dest;
    logic [31:0]      out_reg_commit_value;
    logic [TAG_W-1:0] out_reg_commit_tag;
    logic [TAG_W-1:0] out_lsb_commit_tag;
    logic             out_full;

    modport slave (
        output out_decode_freetag,
        input  in_decode_destination,
        input  in_decode_op,
        input  in_fetch_tag1,
        output out_fetch_value1,
        output out_fetch_ready1,
        input  in_fetch_tag2,
        output out_fetch_value2,
        output out_fetch_ready2,
        input  in_alu_cdb_tag,
        input  in_alu_cdb_value,
        input  in_lsb_cdb_tag,
        input  in_lsb_cdb_value,
        output out_reg_commit_dest,
        output out_reg_commit_value,
        output out_reg_commit_tag,
        output out_lsb_commit_tag,
        output out_full
    );

    modport master (
        input  out_decode_freetag,
        output in_decode_destination,
        output in_decode_op,
        output in_fetch_tag1,
        input  out_fetch_value1,
        input  out_fetch_ready1,
        output in_fetch_tag2,
        input  out_fetch_value2,
        input  out_fetch_ready2,
        output in_alu_cdb_tag,
        output in_alu_cdb_value,
        output in_lsb_cdb_tag,
        output in_lsb_cdb_value,
        input  out_reg_commit_dest,
        input  out_reg_commit_value,
        input  out_reg_commit_tag,
        input  out_lsb_commit_tag,
        input  out_full
    );
endinterface
`default_nettype wire

// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_unit
//  Description : Reorder buffer. Hands decode a free tag, records issued
//                entries, captures ALU/LSB results, answers operand queries
//                with CDB bypass, and retires one entry per cycle in program
//                order to the register file or (stores) to the LSB.
//  Ports       : clk, rst (sync, active-high), rdy (global enable)
//                rob : rob_commit_unit_if.slave (issue, query, CDB, commit)
//  Revision    : 1.0  initial release
// ============================================================================
module rob_commit_unit #(
    parameter int ROB_DEPTH = 15,
    parameter int TAG_W     = 4,
    parameter int OP_W      = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        rdy,
    rob_commit_unit_if.slave rob
);

    // Opcode encodings shared with decode.
    localparam logic [OP_W-1:0] c_op_nop = OP_W'(0);
    localparam logic [OP_W-1:0] c_op_sb  = OP_W'(20);
    localparam logic [OP_W-1:0] c_op_sh  = OP_W'(21);
    localparam logic [OP_W-1:0] c_op_sw  = OP_W'(22);

    // Storage covers every encodable tag so any tag indexes safely; slots
    // 0 and above ROB_DEPTH are never issued into and stay idle.
    localparam int               c_slots = 2**TAG_W;
    localparam logic [TAG_W-1:0] c_depth = TAG_W'(ROB_DEPTH);
    localparam logic [TAG_W-1:0] c_one   = TAG_W'(1);

    logic [c_slots-1:0] r_busy;
    logic [c_slots-1:0] r_ready;
    logic [4:0]         r_dest  [c_slots];
    logic [OP_W-1:0]    r_op    [c_slots];
    logic [31:0]        r_value [c_slots];

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W-1:0] r_count;

    logic [4:0]       r_reg_commit_dest;
    logic [31:0]      r_reg_commit_value;
    logic [TAG_W-1:0] r_reg_commit_tag;
    logic [TAG_W-1:0] r_lsb_commit_tag;

    logic             w_full;
    logic             w_issue;
    logic             w_commit;
    logic             w_head_is_store;
    logic [TAG_W-1:0] w_alu_tag;
    logic [31:0]      w_alu_val;
    logic [TAG_W-1:0] w_lsb_tag;
    logic [31:0]      w_lsb_val;
    logic [32:0]      w_q1;
    logic [32:0]      w_q2;
    logic [26:0]      w_unused_dest;

    // Tags run 1..ROB_DEPTH; 0 is reserved for "no tag".
    function automatic logic [TAG_W-1:0] f_next(input logic [TAG_W-1:0] p);
        return (p == c_depth) ? c_one : p + c_one;
    endfunction

    // Returns {ready, value} for an operand query; live CDB results bypass
    // the stored copy so decode sees them in the cycle they are broadcast.
    function automatic logic [32:0] f_query(input logic [TAG_W-1:0] tag);
        logic [32:0] res;
        res = 33'd0;
        if (tag == '0)
            res = 33'd0;
        else if (tag == w_alu_tag)
            res = {1'b1, w_alu_val};
        else if (tag == w_lsb_tag)
            res = {1'b1, w_lsb_val};
        else if (r_busy[tag] && r_ready[tag])
            res = {1'b1, r_value[tag]};
        return res;
    endfunction

    assign w_alu_tag     = rob.in_alu_cdb_tag;
    assign w_alu_val     = rob.in_alu_cdb_value;
    assign w_lsb_tag     = rob.in_lsb_cdb_tag;
    assign w_lsb_val     = rob.in_lsb_cdb_value;
    assign w_unused_dest = rob.in_decode_destination[31:5];

    assign w_full          = (r_count == c_depth);
    assign w_issue         = rdy && (rob.in_decode_op != c_op_nop) && !w_full;
    assign w_commit        = rdy && r_busy[r_head] && r_ready[r_head];
    assign w_head_is_store = (r_op[r_head] == c_op_sb) || (r_op[r_head] == c_op_sh)
                          || (r_op[r_head] == c_op_sw);

    always_comb begin
        w_q1 = f_query(rob.in_fetch_tag1);
        w_q2 = f_query(rob.in_fetch_tag2);
    end

    assign rob.out_decode_freetag   = w_full ? '0 : r_tail;
    assign rob.out_full             = w_full;
    assign rob.out_fetch_ready1     = w_q1[32];
    assign rob.out_fetch_value1     = w_q1[31:0];
    assign rob.out_fetch_ready2     = w_q2[32];
    assign rob.out_fetch_value2     = w_q2[31:0];
    assign rob.out_reg_commit_dest  = r_reg_commit_dest;
    assign rob.out_reg_commit_value = r_reg_commit_value;
    assign rob.out_reg_commit_tag   = r_reg_commit_tag;
    assign rob.out_lsb_commit_tag   = r_lsb_commit_tag;

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= c_one;
            r_tail  <= c_one;
            r_count <= '0;
        end else begin
            if (w_issue)
                r_tail <= f_next(r_tail);
            if (w_commit)
                r_head <= f_next(r_head);
            if (w_issue && !w_commit)
                r_count <= r_count + c_one;
            else if (!w_issue && w_commit)
                r_count <= r_count - c_one;
        end
    end

    // Entry status. Captures only hit entries busy at the start of the
    // cycle, so the slot being issued this cycle cannot be marked ready.
    // LSB is applied after ALU so it wins on a (illegal) shared tag; the
    // commit clear comes last so a stray late capture on the retiring head
    // cannot leave a stale ready bit behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_ready <= '0;
        end else if (rdy) begin
            if (w_issue) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
            end
            if (w_alu_tag != '0 && r_busy[w_alu_tag])
                r_ready[w_alu_tag] <= 1'b1;
            if (w_lsb_tag != '0 && r_busy[w_lsb_tag])
                r_ready[w_lsb_tag] <= 1'b1;
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
        end
    end

    // Entry payload; gated by the status bits, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (w_issue) begin
                r_dest[r_tail] <= rob.in_decode_destination[4:0];
                r_op[r_tail]   <= rob.in_decode_op;
            end
            if (w_alu_tag != '0 && r_busy[w_alu_tag])
                r_value[w_alu_tag] <= w_alu_val;
            if (w_lsb_tag != '0 && r_busy[w_lsb_tag])
                r_value[w_lsb_tag] <= w_lsb_val;
        end
    end

    // Registered one-cycle commit pulses; idle (and rdy low) drives zeros.
    always_ff @(posedge clk) begin
        if (rst || !w_commit) begin
            r_reg_commit_dest  <= '0;
            r_reg_commit_value <= '0;
            r_reg_commit_tag   <= '0;
            r_lsb_commit_tag   <= '0;
        end else if (w_head_is_store) begin
            r_reg_commit_dest  <= '0;
            r_reg_commit_value <= '0;
            r_reg_commit_tag   <= '0;
            r_lsb_commit_tag   <= r_head;
        end else begin
            r_reg_commit_dest  <= r_dest[r_head];
            r_reg_commit_value <= r_value[r_head];
            r_reg_commit_tag   <= r_head;
            r_lsb_commit_tag   <= '0;
        end
    end

    // Both CDBs broadcasting the same tag in one cycle is a pipeline bug.
    always_ff @(posedge clk) begin
        if (!rst && rdy && w_alu_tag != '0)
            assert (w_alu_tag != w_lsb_tag);
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit_unit
//  Description : Directed self-checking bench for rob_commit_unit: issue and
//                commit latency, full/wrap, out-of-order completion, operand
//                bypass, store commit, rdy freeze and mid-flight reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rob_commit_unit;

    localparam int ROB_DEPTH = 15;
    localparam int TAG_W     = 4;
    localparam int OP_W      = 6;

    localparam logic [OP_W-1:0] c_nop  = 6'd0;
    localparam logic [OP_W-1:0] c_addi = 6'd1;
    localparam logic [OP_W-1:0] c_lw   = 6'd10;
    localparam logic [OP_W-1:0] c_sw   = 6'd22;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rob_commit_unit_if #(.TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    rob_commit_unit #(
        .ROB_DEPTH (ROB_DEPTH),
        .TAG_W     (TAG_W),
        .OP_W      (OP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.in_decode_destination = '0;
        bus.in_decode_op          = c_nop;
        bus.in_fetch_tag1         = '0;
        bus.in_fetch_tag2         = '0;
        bus.in_alu_cdb_tag        = '0;
        bus.in_alu_cdb_value      = '0;
        bus.in_lsb_cdb_tag        = '0;
        bus.in_lsb_cdb_value      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [4:0] dest);
        bus.in_decode_op          = op;
        bus.in_decode_destination = {27'd0, dest};
        tick();
        bus.in_decode_op          = c_nop;
        bus.in_decode_destination = '0;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clear_inputs();

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_freetag", 32'(bus.out_decode_freetag), 32'd1);
        chk("rst_full", 32'(bus.out_full), 32'd0);
        chk("rst_regtag", 32'(bus.out_reg_commit_tag), 32'd0);
        chk("rst_lsbtag", 32'(bus.out_lsb_commit_tag), 32'd0);
        bus.in_fetch_tag1 = 4'd1;
        settle();
        chk("rst_query_ready", 32'(bus.out_fetch_ready1), 32'd0);
        bus.in_fetch_tag1 = '0;

        // ---------------- single ADDI, commit latency ----------------
        bus.in_decode_op = c_addi;
        bus.in_decode_destination = 32'd5;
        settle();
        chk("t1_freetag_first", 32'(bus.out_decode_freetag), 32'd1);
        tick();
        bus.in_decode_op = c_nop;
        bus.in_decode_destination = '0;
        settle();
        chk("t1_freetag_second", 32'(bus.out_decode_freetag), 32'd2);
        bus.in_alu_cdb_tag = 4'd1;
        bus.in_alu_cdb_value = 32'h2A;
        bus.in_fetch_tag1 = 4'd1;
        settle();
        chk("t1_bypass_ready", 32'(bus.out_fetch_ready1), 32'd1);
        chk("t1_bypass_value", bus.out_fetch_value1, 32'h2A);
        tick();
        bus.in_alu_cdb_tag = '0;
        bus.in_alu_cdb_value = '0;
        bus.in_fetch_tag1 = '0;
        settle();
        chk("t1_no_commit_yet", 32'(bus.out_reg_commit_tag), 32'd0);
        tick();
        chk("t1_commit_tag", 32'(bus.out_reg_commit_tag), 32'd1);
        chk("t1_commit_dest", 32'(bus.out_reg_commit_dest), 32'd5);
        chk("t1_commit_value", bus.out_reg_commit_value, 32'h2A);
        tick();
        chk("t1_pulse_ends", 32'(bus.out_reg_commit_tag), 32'd0);

        // ---------------- fill, drop, wrap ----------------
        do_reset();
        for (int i = 1; i <= ROB_DEPTH; i++) begin
            chk($sformatf("t2_freetag_%0d", i), 32'(bus.out_decode_freetag), 32'(i));
            issue(c_addi, 5'(i));
        end
        chk("t2_full", 32'(bus.out_full), 32'd1);
        chk("t2_freetag_full", 32'(bus.out_decode_freetag), 32'd0);
        issue(c_addi, 5'd31);
        chk("t2_still_full", 32'(bus.out_full), 32'd1);
        chk("t2_freetag_after_drop", 32'(bus.out_decode_freetag), 32'd0);
        bus.in_alu_cdb_tag = 4'd1;
        bus.in_alu_cdb_value = 32'h11;
        tick();
        bus.in_alu_cdb_tag = '0;
        bus.in_alu_cdb_value = '0;
        settle();
        chk("t2_full_during_commit", 32'(bus.out_full), 32'd1);
        tick();
        chk("t2_commit_tag", 32'(bus.out_reg_commit_tag), 32'd1);
        chk("t2_commit_dest_not_overwritten", 32'(bus.out_reg_commit_dest), 32'd1);
        chk("t2_commit_value", bus.out_reg_commit_value, 32'h11);
        chk("t2_freetag_wrap", 32'(bus.out_decode_freetag), 32'd1);
        chk("t2_not_full", 32'(bus.out_full), 32'd0);

        // ---------------- out-of-order completion ----------------
        do_reset();
        issue(c_addi, 5'd1);
        issue(c_addi, 5'd2);
        issue(c_addi, 5'd3);
        bus.in_alu_cdb_tag = 4'd3;
        bus.in_alu_cdb_value = 32'h33;
        bus.in_lsb_cdb_tag = 4'd2;
        bus.in_lsb_cdb_value = 32'h22;
        tick();
        bus.in_lsb_cdb_tag = '0;
        bus.in_lsb_cdb_value = '0;
        bus.in_alu_cdb_tag = 4'd1;
        bus.in_alu_cdb_value = 32'h11;
        settle();
        chk("t3_no_early_commit", 32'(bus.out_reg_commit_tag), 32'd0);
        tick();
        bus.in_alu_cdb_tag = '0;
        bus.in_alu_cdb_value = '0;
        settle();
        chk("t3_no_commit_capture_cycle", 32'(bus.out_reg_commit_tag), 32'd0);
        tick();
        chk("t3_commit1_tag", 32'(bus.out_reg_commit_tag), 32'd1);
        chk("t3_commit1_value", bus.out_reg_commit_value, 32'h11);
        tick();
        chk("t3_commit2_tag", 32'(bus.out_reg_commit_tag), 32'd2);
        chk("t3_commit2_value", bus.out_reg_commit_value, 32'h22);
        tick();
        chk("t3_commit3_tag", 32'(bus.out_reg_commit_tag), 32'd3);
        chk("t3_commit3_dest", 32'(bus.out_reg_commit_dest), 32'd3);
        tick();
        chk("t3_idle", 32'(bus.out_reg_commit_tag), 32'd0);

        // ---------------- operand query bypass ----------------
        do_reset();
        for (int i = 1; i <= 4; i++) issue(c_addi, 5'(i));
        bus.in_alu_cdb_tag = 4'd4;
        bus.in_alu_cdb_value = 32'h77;
        bus.in_lsb_cdb_tag = 4'd3;
        bus.in_lsb_cdb_value = 32'h55;
        bus.in_fetch_tag1 = 4'd4;
        bus.in_fetch_tag2 = 4'd3;
        settle();
        chk("t4_alu_bypass_ready", 32'(bus.out_fetch_ready1), 32'd1);
        chk("t4_alu_bypass_value", bus.out_fetch_value1, 32'h77);
        chk("t4_lsb_bypass_ready", 32'(bus.out_fetch_ready2), 32'd1);
        chk("t4_lsb_bypass_value", bus.out_fetch_value2, 32'h55);
        bus.in_fetch_tag2 = 4'd0;
        settle();
        chk("t4_tag0_ready", 32'(bus.out_fetch_ready2), 32'd0);
        chk("t4_tag0_value", bus.out_fetch_value2, 32'd0);
        tick();
        bus.in_alu_cdb_tag = '0;
        bus.in_alu_cdb_value = '0;
        bus.in_lsb_cdb_tag = '0;
        bus.in_lsb_cdb_value = '0;
        bus.in_fetch_tag2 = 4'd2;
        settle();
        chk("t4_stored_ready", 32'(bus.out_fetch_ready1), 32'd1);
        chk("t4_stored_value", bus.out_fetch_value1, 32'h77);
        chk("t4_pending_ready", 32'(bus.out_fetch_ready2), 32'd0);
        chk("t4_pending_value", bus.out_fetch_value2, 32'd0);
        bus.in_fetch_tag1 = '0;
        bus.in_fetch_tag2 = '0;

        // ---------------- store behind load ----------------
        do_reset();
        issue(c_lw, 5'd7);
        issue(c_sw, 5'd0);
        bus.in_lsb_cdb_tag = 4'd2;
        tick();
        bus.in_lsb_cdb_tag = 4'd1;
        bus.in_lsb_cdb_value = 32'hDEAD;
        tick();
        bus.in_lsb_cdb_tag = '0;
        bus.in_lsb_cdb_value = '0;
        settle();
        chk("t5_no_commit_yet", 32'(bus.out_reg_commit_tag), 32'd0);
        tick();
        chk("t5_load_tag", 32'(bus.out_reg_commit_tag), 32'd1);
        chk("t5_load_dest", 32'(bus.out_reg_commit_dest), 32'd7);
        chk("t5_load_value", bus.out_reg_commit_value, 32'hDEAD);
        chk("t5_no_store_yet", 32'(bus.out_lsb_commit_tag), 32'd0);
        tick();
        chk("t5_store_tag", 32'(bus.out_lsb_commit_tag), 32'd2);
        chk("t5_store_regtag", 32'(bus.out_reg_commit_tag), 32'd0);
        chk("t5_store_regvalue", bus.out_reg_commit_value, 32'd0);
        tick();
        chk("t5_store_pulse_ends", 32'(bus.out_lsb_commit_tag), 32'd0);

        // ---------------- rdy low freezes state ----------------
        do_reset();
        rdy = 1'b0;
        bus.in_decode_op = c_addi;
        bus.in_decode_destination = 32'd9;
        settle();
        chk("t6_freetag_rdy_low", 32'(bus.out_decode_freetag), 32'd1);
        tick();
        rdy = 1'b1;
        bus.in_decode_op = c_nop;
        bus.in_decode_destination = '0;
        settle();
        chk("t6_no_issue_when_rdy_low", 32'(bus.out_decode_freetag), 32'd1);

        // ---------------- reset with in-flight entries ----------------
        do_reset();
        issue(c_addi, 5'd1);
        issue(c_addi, 5'd2);
        issue(c_addi, 5'd3);
        bus.in_alu_cdb_tag = 4'd1;
        bus.in_alu_cdb_value = 32'hAA;
        bus.in_lsb_cdb_tag = 4'd2;
        bus.in_lsb_cdb_value = 32'hBB;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        chk("t7_no_reg_pulse", 32'(bus.out_reg_commit_tag), 32'd0);
        chk("t7_no_lsb_pulse", 32'(bus.out_lsb_commit_tag), 32'd0);
        rst = 1'b0;
        settle();
        chk("t7_freetag", 32'(bus.out_decode_freetag), 32'd1);
        chk("t7_not_full", 32'(bus.out_full), 32'd0);
        tick();
        chk("t7_no_late_commit", 32'(bus.out_reg_commit_tag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
